// File: rtl/ser_pkg.sv
// ser_pkg: shared constants, state encoding and payload sizing for the command decoder
package ser_pkg;
  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_SET_ADDR = 4'd1;
  localparam logic [3:0] OP_WRITE    = 4'd2;
  localparam logic [3:0] OP_WRITE_AT = 4'd3;
  localparam logic [2:0] ERR_SYNC    = 3'd1;
  localparam logic [2:0] ERR_OPCODE  = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;
  function automatic logic [2:0] payload_len(input logic [3:0] op);
    return op == OP_NOP      ? 3'd0 :
           op == OP_SET_ADDR ? 3'd2 :
           op == OP_WRITE    ? 3'd4 :
           op == OP_WRITE_AT ? 3'd6 : 3'd0;
  endfunction
endpackage

// File: rtl/ser_cmd_decoder_if.sv
// ser_cmd_decoder_if: received-byte input, command handshake and error strobe bundle
interface ser_cmd_decoder_if;
  logic        rx_full;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        err;
  logic [2:0]  err_code;
  modport master (
    input  rx_full, rx_data, cmd_ready,
    output cmd_valid, cmd_op, cmd_addr, cmd_data, err, err_code
  );
  modport slave (
    output rx_full, rx_data, cmd_ready,
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, err, err_code
  );
endinterface

// File: rtl/ser_cmd_decoder.sv
// ser_cmd_decoder: frames received bytes into checked GPU commands with a one-entry output register
module ser_cmd_decoder
  import ser_pkg::*;
#(
  parameter int TIMEOUT_CLOCKS = 500000
) (
  input logic           clk,
  input logic           reset,
  ser_cmd_decoder_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [47:0] shift_q;
  logic [2:0]  cnt_q;
  logic [7:0]  xor_q;
  logic [TW-1:0] to_q;
  logic        valid_q;
  logic [3:0]  op_o;
  logic [15:0] addr_o;
  logic [31:0] data_o;
  logic        err_q;
  logic [2:0]  code_q;
  logic        fire, complete, load, timeout;
  logic [2:0]  code;
  logic [15:0] addr_n;
  logic [31:0] data_n;
  assign timeout = state_q != S_IDLE && !bus.rx_full && to_q == TW'(TIMEOUT_CLOCKS - 1);
  assign load    = complete && (!valid_q || bus.cmd_ready);
  assign addr_n  = op_q == OP_SET_ADDR ? shift_q[15:0] : op_q == OP_WRITE_AT ? shift_q[47:32] : '0;
  assign data_n  = op_q == OP_WRITE || op_q == OP_WRITE_AT ? shift_q[31:0] : '0;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_op    = op_o;
  assign bus.cmd_addr  = addr_o;
  assign bus.cmd_data  = data_o;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  // next state, error cause and command completion for the current byte or timeout
  always_comb begin
    state_d  = state_q;
    fire     = 1'b0;
    code     = ERR_SYNC;
    complete = 1'b0;
    case (state_q)
      S_IDLE: if (bus.rx_full) begin
        if (bus.rx_data[7:4] != SYNC_NIBBLE) fire = 1'b1;
        else if (bus.rx_data[3:0] > OP_WRITE_AT) begin
          fire = 1'b1;
          code = ERR_OPCODE;
        end
        else state_d = payload_len(bus.rx_data[3:0]) == 3'd0 ? S_CHECK : S_PAYLOAD;
      end
      S_PAYLOAD: if (bus.rx_full && cnt_q == 3'd1) state_d = S_CHECK;
      S_CHECK: if (bus.rx_full) begin
        state_d  = S_IDLE;
        complete = bus.rx_data == xor_q;
        fire     = bus.rx_data != xor_q;
        code     = ERR_CSUM;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d = S_IDLE;
      fire    = 1'b1;
      code    = ERR_TIMEOUT;
    end
    if (complete && !load) begin
      fire = 1'b1;
      code = ERR_OVERRUN;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // packet assembly: header capture, payload shift, running XOR and inter-byte timer
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      to_q    <= '0;
    end else begin
      to_q <= bus.rx_full || state_q == S_IDLE ? '0 : to_q + TW'(1);
      if (bus.rx_full && state_q == S_IDLE) begin
        op_q    <= bus.rx_data[3:0];
        xor_q   <= bus.rx_data;
        cnt_q   <= payload_len(bus.rx_data[3:0]);
        shift_q <= '0;
      end
      if (bus.rx_full && state_q == S_PAYLOAD) begin
        shift_q <= {shift_q[39:0], bus.rx_data};
        xor_q   <= xor_q ^ bus.rx_data;
        cnt_q   <= cnt_q - 3'd1;
      end
    end
  end
  // output command register and error strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_o    <= '0;
      addr_o  <= '0;
      data_o  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= load || (valid_q && !bus.cmd_ready);
      if (load) begin
        op_o   <= op_q;
        addr_o <= addr_n;
        data_o <= data_n;
      end
      err_q <= fire;
      if (fire) code_q <= code;
    end
  end
endmodule

// File: doc/ser_cmd_decoder.md
# ser_cmd_decoder

Frames the byte stream produced by the serial receiver into GPU commands. Each received byte arrives as a one-cycle strobe with its data. The block assembles header, payload and checksum bytes into a command and validates it. It then presents the command on a valid/ready interface to the GPU command logic, and reports framing errors as one-cycle error strobes.

## Interface
- `TIMEOUT_CLOCKS`, default 500000 (20 bit times at 2 kbaud, 50 MHz clock): inter-byte timeout while a packet is open.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rx_full`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte, valid while `rx_full`=1.
- `cmd_valid`  out  1  command register holds an unconsumed command.
- `cmd_ready`  in  1  consumer accepts the command when `cmd_valid`&&`cmd_ready`.
- `cmd_op`  out  4  opcode.
- `cmd_addr`  out  16  address field; 0 when the opcode carries none.
- `cmd_data`  out  32  data field; 0 when the opcode carries none.
- `err`  out  1  one-cycle error strobe.
- `err_code`  out  3  error cause, valid with `err`; holds its last value otherwise.

## Operation
- Packet format: header, then payload, then checksum.
  - Header: bits [7:4] must equal the sync nibble 0xA; bits [3:0] are the opcode.
  - Payload length by opcode: 0 NOP → 0 bytes; 1 SET_ADDR → 2 bytes (addr); 2 WRITE → 4 bytes (data); 3 WRITE_AT → 6 bytes (addr, then data).
  - All multi-byte fields are big-endian.
  - Checksum byte = XOR of header and all payload bytes.
- States:
  - IDLE: waits for a header. On `rx_full`:
    - Sync nibble wrong → `err` with code SYNC; stay IDLE.
    - Opcode above 3 → `err` with code OPCODE; stay IDLE.
    - Otherwise → PAYLOAD, or CHECK if the payload length is 0.
  - PAYLOAD: shifts each byte into the field register and decrements the byte counter. When the last byte arrives → CHECK.
  - CHECK: on `rx_full`, compares the byte with the running XOR.
    - Mismatch → `err` with code CSUM.
    - Match → completes the command.
    - Either way → IDLE.
- Timeout: in PAYLOAD/CHECK, a counter restarts on every accepted byte. After `TIMEOUT_CLOCKS` cycles with no `rx_full`: abort, `err` with code TIMEOUT, return to IDLE. The counter width holds `TIMEOUT_CLOCKS`; it does not wrap.
- Output register: one entry, independent of assembly, so reception continues while a command waits.
  - Completion with `cmd_valid`=0, or with `cmd_valid`&&`cmd_ready` in the same cycle → load the new command; `cmd_valid`=1.
  - Completion with `cmd_valid`&&!`cmd_ready` → drop the new command, `err` with code OVERRUN; the held command is unchanged.
  - `cmd_valid`&&`cmd_ready` with no completion → `cmd_valid` falls next cycle.
- Only one error can occur per cycle, since at most one byte arrives per cycle.
- Reset at any point: back to IDLE and discard the partial packet.
  - Reset values: `cmd_valid` 0, `cmd_op` 0, `cmd_addr` 0, `cmd_data` 0, `err` 0, `err_code` 0.

## Timing
- `cmd_valid` rises in the cycle after the `rx_full` carrying a correct checksum.
- `err` is high exactly one cycle, in the cycle after the offending `rx_full`, or after the timeout expires.
- Command fields are stable while `cmd_valid`=1 and not consumed.
- `rx_full` is never held more than one cycle. Bytes are at least one bit time apart, so back-to-back strobes need no buffering.

## Structure
- Package `ser_pkg` holds:
  - sync nibble 0xA;
  - opcode constants OP_NOP=0, OP_SET_ADDR=1, OP_WRITE=2, OP_WRITE_AT=3;
  - error codes SYNC=1, OPCODE=2, CSUM=3, TIMEOUT=4, OVERRUN=5;
  - state enum;
  - payload-length function of the opcode.
- Single module. The 48-bit payload shift register and the timeout counter stay inline; no sub-module.

## Test plan
- Send A3 12 34 DE AD BE EF A7 → one cycle after the last strobe, `cmd_valid`=1, `cmd_op`=3, `cmd_addr`=0x1234, `cmd_data`=0xDEADBEEF. Consume with `cmd_ready`.
- Send A0 A0 → NOP: `cmd_op`=0, `cmd_addr`=0, `cmd_data`=0. Then send A1 00 10 00 (correct checksum is B1) → `err` with code 3; no `cmd_valid`.
- Send 5A, then A7 → two `err` strobes, codes 1 and 2. Then A0 A0 → a valid NOP is accepted.
- Send A2 11, then idle for `TIMEOUT_CLOCKS` cycles (bench override 100) → `err` with code 4 exactly once. Then A0 A0 → NOP accepted.
- Hold `cmd_ready`=0 and send two NOP packets → first held, `err` with code 5 on the second. Raise `cmd_ready` → one handshake, `cmd_valid` falls.
- Assert `reset` after A3 12 → no output. Then A0 A0 → NOP accepted, with no stale bytes merged into the packet.
